// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared op codes, FSM encoding and default sizes for the memory access unit
package mem_access_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 6;
  localparam int MEM_LAST_DEF = 50;
  typedef enum logic [1:0] {OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ACCESS = 2'b01, S_RESP = 2'b10} state_e;
endpackage

// File: rtl/mem_req_check.sv
// mem_req_check: flags illegal requests (op_i op code, addr_i address -> illegal_o)
module mem_req_check
  import mem_access_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MEM_LAST = MEM_LAST_DEF
) (
  input  op_e               op_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              illegal_o
);
  assign illegal_o = (op_i == OP_RSVD) | ((op_i == OP_FETCH) & addr_i[0]) | (32'(addr_i) > MEM_LAST);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding fetch/load/store sequencer (req_* in, resp_* out, IR/MDR regs, memory port)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MEM_LAST = MEM_LAST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] instr_reg,
  output logic [DATA_W-1:0] mem_data_reg,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);
  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ir_q, mdr_q;
  logic              illegal;
  mem_req_check #(.ADDR_W(ADDR_W), .MEM_LAST(MEM_LAST)) u_check (
    .op_i      (op_q),
    .addr_i    (addr_q),
    .illegal_o (illegal)
  );
  always_ff @(posedge clk)
    state_q <= reset ? S_IDLE : state_d;
  always_comb begin
    state_d = state_q == S_IDLE   ? (req_valid ? S_ACCESS : S_IDLE) :
              state_q == S_ACCESS ? S_RESP : S_IDLE;
  end
  // Outputs are gated by reset so an in-flight transaction is aborted the moment reset rises.
  always_comb begin
    req_ready  = (state_q == S_IDLE) & ~reset;
    memWrite   = (state_q == S_ACCESS) & (op_q == OP_STORE) & ~illegal & ~reset;
    resp_valid = (state_q == S_RESP) & ~reset;
    resp_err   = resp_valid & illegal;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      if (req_valid & req_ready) begin
        op_q    <= op_e'(req_op);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if ((state_q == S_ACCESS) & ~illegal & (op_q == OP_FETCH)) ir_q <= readData;
      if ((state_q == S_ACCESS) & ~illegal & (op_q == OP_LOAD)) mdr_q <= readData;
    end
  end
  assign memAdr       = addr_q;
  assign writeData    = wdata_q;
  assign instr_reg    = ir_q;
  assign mem_data_reg = mdr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a 64-word memory model
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid, resp_err, memWrite;
  logic [15:0] instr_reg, mem_data_reg, writeData, readData;
  logic [5:0]  memAdr;
  logic [15:0] mem [0:63];
  int checks = 0, errors = 0;
  int wr_cnt = 0, rv_cnt = 0, acc_cnt = 0;
  int w0, r0, a0;
  logic [15:0] burst_exp [0:2];
  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .instr_reg    (instr_reg),
    .mem_data_reg (mem_data_reg),
    .memWrite     (memWrite),
    .memAdr       (memAdr),
    .writeData    (writeData),
    .readData     (readData)
  );
  always #5 clk = ~clk;
  assign readData = mem[memAdr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[0]  <= 16'h52C6;
      mem[2]  <= 16'h1111;
      mem[4]  <= 16'h2222;
      mem[6]  <= 16'h3333;
      mem[30] <= 16'd3;
    end else if (memWrite) mem[memAdr] <= writeData;
    wr_cnt  <= wr_cnt + (memWrite ? 1 : 0);
    rv_cnt  <= rv_cnt + (resp_valid ? 1 : 0);
    acc_cnt <= acc_cnt + ((req_valid & req_ready) ? 1 : 0);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_req(input string tag, input logic [1:0] op, input logic [5:0] a,
                         input logic [15:0] wd, input logic exp_err, input logic exp_wr);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    chk({tag, ".ready"}, req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = ~op; req_addr = ~a; req_wdata = ~wd;
    @(negedge clk);
    chk({tag, ".access_rv"}, resp_valid, 0);
    chk({tag, ".access_wr"}, memWrite, exp_wr);
    @(negedge clk);
    chk({tag, ".resp_rv"}, resp_valid, 1);
    chk({tag, ".resp_err"}, resp_err, exp_err);
    chk({tag, ".resp_ready"}, req_ready, 0);
    chk({tag, ".resp_wr"}, memWrite, 0);
    @(negedge clk);
    chk({tag, ".post_rv"}, resp_valid, 0);
    chk({tag, ".post_ready"}, req_ready, 1);
  endtask
  initial begin
    burst_exp[0] = 16'h1111; burst_exp[1] = 16'h2222; burst_exp[2] = 16'h3333;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", req_ready, 0);
    chk("rst.rv", resp_valid, 0);
    chk("rst.ir", instr_reg, 0);
    chk("rst.mdr", mem_data_reg, 0);
    chk("rst.adr", memAdr, 0);
    chk("rst.wdata", writeData, 0);
    chk("rst.wr", memWrite, 0);
    reset = 1'b0;
    #1 chk("rst.ready_after", req_ready, 1);
    run_req("fetch0", 2'b00, 6'd0, 16'h0, 1'b0, 1'b0);
    chk("fetch0.ir", instr_reg, 16'h52C6);
    chk("fetch0.mdr", mem_data_reg, 16'h0);
    run_req("load30", 2'b01, 6'd30, 16'h0, 1'b0, 1'b0);
    chk("load30.mdr", mem_data_reg, 16'd3);
    chk("load30.ir", instr_reg, 16'h52C6);
    run_req("fetch5", 2'b00, 6'd5, 16'h0, 1'b1, 1'b0);
    chk("fetch5.ir", instr_reg, 16'h52C6);
    chk("fetch5.mdr", mem_data_reg, 16'd3);
    w0 = wr_cnt;
    run_req("store26", 2'b10, 6'd26, 16'h00AA, 1'b0, 1'b1);
    chk("store26.wr_cycles", wr_cnt - w0, 1);
    chk("store26.mem", mem[26], 16'h00AA);
    chk("store26.mdr", mem_data_reg, 16'd3);
    run_req("load26", 2'b01, 6'd26, 16'h0, 1'b0, 1'b0);
    chk("load26.mdr", mem_data_reg, 16'h00AA);
    w0 = wr_cnt;
    run_req("store52", 2'b10, 6'd52, 16'hBEEF, 1'b1, 1'b0);
    run_req("op11", 2'b11, 6'd2, 16'hCAFE, 1'b1, 1'b0);
    run_req("store51", 2'b10, 6'd51, 16'h5555, 1'b1, 1'b0);
    chk("illegal.wr_cycles", wr_cnt - w0, 0);
    chk("illegal.mdr", mem_data_reg, 16'h00AA);
    w0 = wr_cnt; r0 = rv_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 6'd28; req_wdata = 16'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rstmid.wr", memWrite, 0);
    chk("rstmid.ready", req_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid.ready_after", req_ready, 1);
    chk("rstmid.rv", resp_valid, 0);
    @(negedge clk);
    chk("rstmid.mem28", mem[28], 0);
    chk("rstmid.wr_cycles", wr_cnt - w0, 0);
    chk("rstmid.rv_pulses", rv_cnt - r0, 0);
    chk("rstmid.ir", instr_reg, 0);
    chk("rstmid.mdr", mem_data_reg, 0);
    chk("rstmid.adr", memAdr, 0);
    a0 = acc_cnt;
    req_valid = 1'b1; req_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      req_addr = 6'(2 * i + 2);
      chk("burst.ready_idle", req_ready, 1);
      @(negedge clk);
      req_addr = 6'(2 * i + 9);
      chk("burst.ready_access", req_ready, 0);
      @(negedge clk);
      req_addr = 6'(2 * i + 11);
      chk("burst.rv", resp_valid, 1);
      chk("burst.err", resp_err, 0);
      chk("burst.ir", instr_reg, burst_exp[i]);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("burst.accepts", acc_cnt - a0, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
